// File: rtl/oehb_fifo_pkg.sv
// Helpers shared by the opaque elastic buffer files: pointer and occupancy widths.
package oehb_fifo_pkg;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/oehb_fifo_dataless.sv
// Control half of the opaque buffer: occupancy, head/tail pointers and the handshake.
// Also usable alone for control-only channels that carry no data.
module oehb_fifo_dataless
    import oehb_fifo_pkg::*;
#(
    parameter  int NUM_SLOTS = 2,
    localparam int PW        = idx_width(NUM_SLOTS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ins_valid,
    output logic          ins_ready,
    output logic          outs_valid,
    input  logic          outs_ready,
    output logic          wr_en,
    output logic [PW-1:0] wr_idx,
    output logic [PW-1:0] rd_idx
);

    localparam int            CW   = cnt_width(NUM_SLOTS);
    localparam logic [PW-1:0] LAST = PW'(NUM_SLOTS - 1);
    localparam logic [CW-1:0] FULL = CW'(NUM_SLOTS);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    always_comb begin
        outs_valid = (count_q != '0);
        // Full still accepts when the consumer drains in the same cycle.
        ins_ready  = (count_q != FULL) | outs_ready;
        push       = ins_valid & ins_ready;
        pop        = outs_valid & outs_ready;

        head_d = head_q;
        if (pop) begin
            head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
        end

        tail_d = tail_q;
        if (push) begin
            tail_d = (tail_q == LAST) ? '0 : tail_q + 1'b1;
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        wr_en  = push;
        wr_idx = tail_q;
        rd_idx = head_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/oehb_fifo.sv
// Opaque elastic buffer: forward path (outs/outs_valid) comes from registers only,
// ins_ready stays combinational from outs_ready so throughput is one word per cycle.
module oehb_fifo
    import oehb_fifo_pkg::*;
#(
    parameter int DATA_TYPE = 32,
    parameter int NUM_SLOTS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] ins,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    output logic [DATA_TYPE-1:0] outs,
    output logic                 outs_valid,
    input  logic                 outs_ready
);

    localparam int PW = idx_width(NUM_SLOTS);

    logic                 wr_en;
    logic [PW-1:0]        wr_idx;
    logic [PW-1:0]        rd_idx;
    logic [DATA_TYPE-1:0] mem_q [NUM_SLOTS];
    logic [DATA_TYPE-1:0] mem_d [NUM_SLOTS];

    oehb_fifo_dataless #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .rd_idx     (rd_idx)
    );

    // When full, push and pop share one slot; the reader sees the old word before the edge.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = ins;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign outs = mem_q[rd_idx];

endmodule

// File: tb/tb_oehb_fifo.sv
// Directed and scoreboard checks of oehb_fifo at depths 1, 2 and 3.
module tb_oehb_fifo;

    typedef struct {
        int          dut;
        logic        iv;
        logic        ordy;
        logic [31:0] din;
        logic        exp_ov;
        logic [31:0] exp_out;
        logic        exp_ir;
    } vec_t;

    logic clk;
    logic rst;

    logic [31:0] in1, in2, in3, o1, o2, o3;
    logic        iv1, iv2, iv3, ir1, ir2, ir3;
    logic        ov1, ov2, ov3, or1, or2, or3;

    int checks;
    int errors;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];

    oehb_fifo #(.DATA_TYPE(32), .NUM_SLOTS(1)) dut1 (
        .clk(clk), .rst(rst), .ins(in1), .ins_valid(iv1), .ins_ready(ir1),
        .outs(o1), .outs_valid(ov1), .outs_ready(or1)
    );
    oehb_fifo #(.DATA_TYPE(32), .NUM_SLOTS(2)) dut2 (
        .clk(clk), .rst(rst), .ins(in2), .ins_valid(iv2), .ins_ready(ir2),
        .outs(o2), .outs_valid(ov2), .outs_ready(or2)
    );
    oehb_fifo #(.DATA_TYPE(32), .NUM_SLOTS(3)) dut3 (
        .clk(clk), .rst(rst), .ins(in3), .ins_valid(iv3), .ins_ready(ir3),
        .outs(o3), .outs_valid(ov3), .outs_ready(or3)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic drive(input int which, input logic iv, input logic ordy, input logic [31:0] din);
        case (which)
            1: begin iv1 = iv; or1 = ordy; in1 = din; end
            2: begin iv2 = iv; or2 = ordy; in2 = din; end
            default: begin iv3 = iv; or3 = ordy; in3 = din; end
        endcase
    endtask

    task automatic sample(input int which, output logic ov, output logic [31:0] o, output logic ir);
        case (which)
            1: begin ov = ov1; o = o1; ir = ir1; end
            2: begin ov = ov2; o = o2; ir = ir2; end
            default: begin ov = ov3; o = o3; ir = ir3; end
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(int dut, logic iv, logic ordy, logic [31:0] din,
                                logic exp_ov, logic [31:0] exp_out, logic exp_ir);
        vec_t v;
        v.dut = dut; v.iv = iv; v.ordy = ordy; v.din = din;
        v.exp_ov = exp_ov; v.exp_out = exp_out; v.exp_ir = exp_ir;
        return v;
    endfunction

    task automatic check_now(input int which, input string tag, input logic exp_ov,
                             input logic [31:0] exp_out, input logic exp_ir);
        logic        ov, ir;
        logic [31:0] o;
        sample(which, ov, o, ir);
        chk({tag, " outs_valid"}, {31'd0, ov}, {31'd0, exp_ov});
        if (exp_ov) chk({tag, " outs"}, o, exp_out);
        chk({tag, " ins_ready"}, {31'd0, ir}, {31'd0, exp_ir});
    endtask

    initial begin
        logic        ov, ir, iv, ordy, prev_ov, prev_or, m_push, m_pop, exp_ir, hold;
        logic [31:0] o, din, prev_out;
        int          head_m, tail_m, head_wraps, tail_wraps;

        checks = 0;
        errors = 0;
        drive(1, 0, 0, 0);
        drive(2, 0, 0, 0);
        drive(3, 0, 0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Depth 3 fill, backpressure, full push+pop, drain
        vecs.push_back(mk(3, 1, 0, 32'h10, 0, 32'h00, 1));
        vecs.push_back(mk(3, 1, 0, 32'h20, 1, 32'h10, 1));
        vecs.push_back(mk(3, 1, 0, 32'h30, 1, 32'h10, 1));
        vecs.push_back(mk(3, 1, 0, 32'h40, 1, 32'h10, 0));
        vecs.push_back(mk(3, 1, 0, 32'h40, 1, 32'h10, 0));
        vecs.push_back(mk(3, 1, 1, 32'h40, 1, 32'h10, 1));
        vecs.push_back(mk(3, 0, 1, 32'h00, 1, 32'h20, 1));
        vecs.push_back(mk(3, 0, 1, 32'h00, 1, 32'h30, 1));
        vecs.push_back(mk(3, 0, 1, 32'h00, 1, 32'h40, 1));
        vecs.push_back(mk(3, 0, 1, 32'h00, 0, 32'h00, 1));
        // Depth 1, outs_ready toggling, input 5,6,7
        vecs.push_back(mk(1, 1, 1, 32'd5, 0, 32'd0, 1));
        vecs.push_back(mk(1, 1, 0, 32'd6, 1, 32'd5, 0));
        vecs.push_back(mk(1, 1, 1, 32'd6, 1, 32'd5, 1));
        vecs.push_back(mk(1, 1, 0, 32'd7, 1, 32'd6, 0));
        vecs.push_back(mk(1, 1, 1, 32'd7, 1, 32'd6, 1));
        vecs.push_back(mk(1, 0, 0, 32'd0, 1, 32'd7, 0));
        vecs.push_back(mk(1, 0, 1, 32'd0, 1, 32'd7, 1));
        vecs.push_back(mk(1, 0, 0, 32'd0, 0, 32'd0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].dut, vecs[i].iv, vecs[i].ordy, vecs[i].din);
            #1;
            check_now(vecs[i].dut, $sformatf("vec%0d", i), vecs[i].exp_ov,
                      vecs[i].exp_out, vecs[i].exp_ir);
        end

        // Depth 2 streaming, one word per cycle
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            drive(2, 1, 1, i);
            #1;
            check_now(2, $sformatf("stream%0d", i), (i > 1), i - 1, 1'b1);
        end
        @(negedge clk);
        drive(2, 0, 1, 0);
        #1;
        check_now(2, "stream_tail", 1'b1, 32'd8, 1'b1);
        @(negedge clk);
        #1;
        check_now(2, "stream_empty", 1'b0, 32'd0, 1'b1);

        // Depth 2 asynchronous reset mid-stream
        @(negedge clk);
        drive(2, 1, 0, 32'hA1);
        @(negedge clk);
        drive(2, 1, 0, 32'hA2);
        @(negedge clk);
        drive(2, 0, 0, 0);
        #1;
        check_now(2, "pre_reset", 1'b1, 32'hA1, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        sample(2, ov, o, ir);
        chk("reset outs_valid", {31'd0, ov}, 32'd0);
        chk("reset outs", o, 32'd0);
        chk("reset ins_ready", {31'd0, ir}, 32'd1);
        #1;
        rst = 1'b1;
        @(negedge clk);
        drive(2, 1, 0, 32'hB0);
        @(negedge clk);
        drive(2, 0, 1, 0);
        #1;
        check_now(2, "post_reset", 1'b1, 32'hB0, 1'b1);
        @(negedge clk);
        #1;
        check_now(2, "post_reset_empty", 1'b0, 32'd0, 1'b1);
        drive(2, 0, 0, 0);

        // Depth 3 random traffic against a scoreboard
        head_m = 0; tail_m = 0; head_wraps = 0; tail_wraps = 0;
        prev_ov = 0; prev_or = 0; prev_out = 0; hold = 0;
        iv = 0; din = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (!hold) begin
                iv  = ($urandom_range(0, 1) == 1);
                din = $urandom;
            end
            ordy = ($urandom_range(0, 1) == 1);
            drive(3, iv, ordy, din);
            #1;
            sample(3, ov, o, ir);
            exp_ir = (exp_q.size() != 3) | ordy;
            chk("rand ins_ready", {31'd0, ir}, {31'd0, exp_ir});
            chk("rand outs_valid", {31'd0, ov}, {31'd0, exp_q.size() != 0});
            if (prev_ov && !prev_or) begin
                chk("rand stable_valid", {31'd0, ov}, 32'd1);
                chk("rand stable_outs", o, prev_out);
            end
            m_pop  = (exp_q.size() != 0) && ordy;
            m_push = iv && exp_ir;
            if (m_pop) begin
                chk("rand outs", o, exp_q[0]);
                void'(exp_q.pop_front());
                if (head_m == 2) begin head_m = 0; head_wraps++; end else head_m++;
            end
            if (m_push) begin
                exp_q.push_back(din);
                if (tail_m == 2) begin tail_m = 0; tail_wraps++; end else tail_m++;
            end
            hold     = iv && !exp_ir;
            prev_ov  = ov;
            prev_or  = ordy;
            prev_out = o;
        end
        chk("head_wraps>=50", {31'd0, head_wraps >= 50}, 32'd1);
        chk("tail_wraps>=50", {31'd0, tail_wraps >= 50}, 32'd1);
        drive(3, 0, 0, 0);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
